// File: rtl/ps2_frame_receiver_pkg.sv
// ps2_frame_receiver_pkg
//   Definitions shared by the PS/2 frame receiver:
//   - the deframer FSM state encoding (2-bit);
//   - the number of data bits in a frame;
//   - the odd-parity helper used when parity checking is compiled in.
package ps2_frame_receiver_pkg;

  typedef enum logic [1:0] {
    PS2_IDLE   = 2'd0,
    PS2_DATA   = 2'd1,
    PS2_PARITY = 2'd2,
    PS2_STOP   = 2'd3
  } ps2State_t;

  localparam int PS2_DATA_BITS = 8;

  // True when the byte plus its parity bit carry an odd number of ones.
  function automatic logic oddParityOk(input logic [7:0] b, input logic p);
    return ^{b, p};
  endfunction

endpackage

// File: rtl/ps2_frame_receiver_if.sv
// ps2_frame_receiver_if
//   Byte stream and status bundle between the PS/2 receiver and the SoC
//   keyboard decoder.
//   data       : scan code at the FIFO head (meaningful only while valid)
//   valid      : FIFO holds at least one byte
//   ready      : consumer pop; a byte leaves on a cycle with valid && ready
//   frameError : one-cycle pulse on a bad start/stop/parity or a timeout
//   overrun    : one-cycle pulse when a good byte is dropped (FIFO full)
//   busy       : a frame is in progress
//   Modports: master = receiver side, slave = consumer side.
interface ps2_frame_receiver_if;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       frameError;
  logic       overrun;
  logic       busy;

  modport master (
    output data, valid, frameError, overrun, busy,
    input  ready
  );

  modport slave (
    input  data, valid, frameError, overrun, busy,
    output ready
  );
endinterface

// File: rtl/ps2_frame_receiver_fifo.sv
// ps2_byte_fifo
//   Show-ahead byte FIFO with synchronous active-low reset.
//   clk, reset : clock, synchronous active-low reset (flushes the FIFO)
//   push       : write pushData (taken when not full, or when full with a pop)
//   pushData   : byte to write
//   pop        : remove the head byte (ignored when empty)
//   popData    : head byte, forced to 0 while empty
//   empty      : no bytes held
//   overrun    : one-cycle pulse after a push was dropped because of full
module ps2_byte_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] pushData,
  input  logic             pop,
  output logic [WIDTH-1:0] popData,
  output logic             empty,
  output logic             overrun
);

  localparam int AW = $clog2(DEPTH);

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wrPtr;
  logic [AW:0]      rdPtr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             full;
  logic             doPush;
  logic             doPop;
  logic             dropByte;

  assign empty = (wrPtr == rdPtr);
  assign full  = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);

  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign doPop    = pop && !empty;
  assign doPush   = push && (!full || doPop);
  assign dropByte = push && full && !doPop;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      overrun <= 1'b0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      overrun <= dropByte;
    end
  end

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr[AW-1:0]] <= pushData;
  end

  assign popData = empty ? '0 : mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/ps2_frame_receiver.sv
// ps2_frame_receiver
//   Deframes PS/2 keyboard frames (start 0, 8 data bits LSB first, odd
//   parity, stop 1) from debounced, clk-synchronous ps2Clk/ps2Data, applies
//   a watchdog to stalled frames and queues good bytes in a show-ahead FIFO.
//   Parameters: TIMEOUT_CYCLES (idle cycles between falling edges before a
//   frame is aborted), FIFO_DEPTH (power of two, >= 2).
//   Ports: clk, reset (synchronous, active-low), ps2Clk, ps2Data, and the
//   rx bundle (data/valid/ready/frameError/overrun/busy, master side).
//   Build option: define PS2_PARITY_CHECK_EN to reject bytes whose parity
//   bit is wrong; otherwise the parity bit is sampled and ignored.
module ps2_frame_receiver
  import ps2_frame_receiver_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16000,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic ps2Clk,
  input  logic ps2Data,
  ps2_frame_receiver_if.master rx
);

  localparam int             WDW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT_CYCLES);

  ps2State_t      state;
  ps2State_t      stateNext;
  logic           ps2ClkPrev;
  logic [2:0]     bitCnt;
  logic [2:0]     bitCntNext;
  logic [7:0]     shreg;
  logic [7:0]     shregNext;
  logic           parityBit;
  logic           parityNext;
  logic [WDW-1:0] wdCnt;
  logic           frameErrorReg;
  logic           errNext;
  logic           byteOk;
  logic           parityOk;
  logic           fe;
  logic           timeout;
  logic           fifoEmpty;

  assign fe = ps2ClkPrev && !ps2Clk;

  // A falling edge in the same cycle always takes precedence over the watchdog.
  assign timeout = (state != PS2_IDLE) && !fe && (wdCnt == WD_LIMIT);

`ifdef PS2_PARITY_CHECK_EN
  assign parityOk = oddParityOk(shreg, parityBit);
`else
  assign parityOk = 1'b1;
`endif

  // ---- state / control registers ----
  always_ff @(posedge clk) begin
    if (!reset) begin
      state         <= PS2_IDLE;
      ps2ClkPrev    <= 1'b1;
      wdCnt         <= '0;
      frameErrorReg <= 1'b0;
    end else begin
      state         <= stateNext;
      ps2ClkPrev    <= ps2Clk;
      frameErrorReg <= errNext;
      if (state == PS2_IDLE || fe || timeout) wdCnt <= '0;
      else                                    wdCnt <= wdCnt + 1'b1;
    end
  end

  // ---- frame payload registers (no reset needed) ----
  always_ff @(posedge clk) begin
    bitCnt    <= bitCntNext;
    shreg     <= shregNext;
    parityBit <= parityNext;
  end

  always_comb begin
    stateNext  = state;
    bitCntNext = bitCnt;
    shregNext  = shreg;
    parityNext = parityBit;
    errNext    = 1'b0;
    byteOk     = 1'b0;
    if (timeout) begin
      stateNext = PS2_IDLE;
      errNext   = 1'b1;
    end else if (fe) begin
      unique case (state)
        PS2_IDLE: begin
          if (!ps2Data) begin
            stateNext  = PS2_DATA;
            bitCntNext = '0;
          end else begin
            errNext = 1'b1;
          end
        end
        PS2_DATA: begin
          // LSB arrives first, so shift right and enter at bit 7.
          shregNext  = {ps2Data, shreg[7:1]};
          bitCntNext = bitCnt + 1'b1;
          if (bitCnt == 3'(PS2_DATA_BITS - 1)) stateNext = PS2_PARITY;
        end
        PS2_PARITY: begin
          parityNext = ps2Data;
          stateNext  = PS2_STOP;
        end
        PS2_STOP: begin
          stateNext = PS2_IDLE;
          if (ps2Data && parityOk) byteOk  = 1'b1;
          else                     errNext = 1'b1;
        end
        default: stateNext = PS2_IDLE;
      endcase
    end
  end

  ps2_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) uFifo (
    .clk      (clk),
    .reset    (reset),
    .push     (byteOk),
    .pushData (shreg),
    .pop      (rx.ready),
    .popData  (rx.data),
    .empty    (fifoEmpty),
    .overrun  (rx.overrun)
  );

  assign rx.valid      = !fifoEmpty;
  assign rx.frameError = frameErrorReg;
  assign rx.busy       = (state != PS2_IDLE);

endmodule

// File: tb/tb_ps2_frame_receiver.sv
module tb_ps2_frame_receiver;

  localparam int TIMEOUT = 16000;
  localparam int DEPTH   = 4;
  localparam int H       = 20;   // PS/2 half period in clk cycles

`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic ps2Clk;
  logic ps2Data;
  int   compared   = 0;
  int   mismatched = 0;
  logic [7:0] q[$];

  ps2_frame_receiver_if rxIf ();

  ps2_frame_receiver #(
    .TIMEOUT_CYCLES (TIMEOUT),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .ps2Clk  (ps2Clk),
    .ps2Data (ps2Data),
    .rx      (rxIf)
  );

  always #5 clk = ~clk;

  // Reference rule: stop must be 1; with checking on, ones(byte)+parity is odd.
  function automatic bit frameGood(input logic [7:0] b, input logic par, input logic stopb);
    int ones;
    ones = $countones(b) + int'(par);
    return (stopb == 1'b1) && (!PCHK || (ones % 2 == 1));
  endfunction

  function automatic logic goodParity(input logic [7:0] b);
    return ($countones(b) % 2 == 0) ? 1'b1 : 1'b0;
  endfunction

  // Drives the first n bits of the frame; returns in the cycle of the last falling edge.
  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      ps2Data = bits[i];
      repeat (H) @(posedge clk);
      #1 ps2Clk = 1'b0;
      if (i < n - 1) begin
        repeat (H) @(posedge clk);
        #1 ps2Clk = 1'b1;
      end
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stopb);
    send_bits({stopb, par, b, 1'b0}, 11);
  endtask

  task automatic release_clk();
    ps2Clk = 1'b1;
    repeat (H) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ps2Clk = 1'b1; ps2Data = 1'b1; rxIf.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", rxIf.valid); end
    compared++; if (rxIf.data !== 8'h00) begin mismatched++; $display("FAIL reset_data: got %h want 00", rxIf.data); end
    compared++; if (rxIf.frameError !== 1'b0 || rxIf.overrun !== 1'b0) begin mismatched++; $display("FAIL reset_pulses: got fe=%b ov=%b want 0 0", rxIf.frameError, rxIf.overrun); end
    compared++; if (rxIf.busy !== 1'b0) begin mismatched++; $display("FAIL reset_busy: got %b want 0", rxIf.busy); end
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_frame_1c();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 2);  // start + first data bit
    @(posedge clk); #1;
    compared++; if (rxIf.busy !== 1'b1) begin mismatched++; $display("FAIL busy_rise: got %b want 1", rxIf.busy); end
    release_clk();
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0} >> 2, 9);
    @(posedge clk); #1;
    compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== 8'h1C) begin mismatched++; $display("FAIL frame1c_data: got v=%b d=%h want v=1 d=1c", rxIf.valid, rxIf.data); end
    compared++; if (rxIf.frameError !== 1'b0) begin mismatched++; $display("FAIL frame1c_err: got %b want 0", rxIf.frameError); end
    compared++; if (rxIf.busy !== 1'b0) begin mismatched++; $display("FAIL busy_fall: got %b want 0", rxIf.busy); end
    release_clk();
    rxIf.ready = 1'b1;
    @(posedge clk); #1;
    rxIf.ready = 1'b0;
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL frame1c_pop: got v=%b want 0", rxIf.valid); end
  endtask

  task automatic test_parity_error();
    logic expErr;
    expErr = PCHK;
    send_frame(8'h1C, 1'b1, 1'b1);
    @(posedge clk); #1;
    compared++; if (rxIf.frameError !== expErr) begin mismatched++; $display("FAIL parity_err: got %b want %b", rxIf.frameError, expErr); end
    compared++; if (rxIf.valid !== !expErr) begin mismatched++; $display("FAIL parity_valid: got %b want %b", rxIf.valid, !expErr); end
    @(posedge clk); #1;
    compared++; if (rxIf.frameError !== 1'b0) begin mismatched++; $display("FAIL parity_err_width: got %b want 0", rxIf.frameError); end
    release_clk();
    if (rxIf.valid) begin
      compared++; if (rxIf.data !== 8'h1C) begin mismatched++; $display("FAIL parity_data: got %h want 1c", rxIf.data); end
      rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
    end
  endtask

  task automatic test_overrun();
    logic [7:0] seq [5];
    seq = '{8'hF0, 8'h1C, 8'hE0, 8'h75, 8'h12};
    for (int i = 0; i < 5; i++) begin
      send_frame(seq[i], goodParity(seq[i]), 1'b1);
      @(posedge clk); #1;
      compared++; if (rxIf.overrun !== (i == 4)) begin mismatched++; $display("FAIL overrun_%0d: got %b want %b", i, rxIf.overrun, (i == 4)); end
      compared++; if (rxIf.frameError !== 1'b0) begin mismatched++; $display("FAIL overrun_err_%0d: got %b want 0", i, rxIf.frameError); end
      @(posedge clk); #1;
      compared++; if (rxIf.overrun !== 1'b0) begin mismatched++; $display("FAIL overrun_width_%0d: got %b want 0", i, rxIf.overrun); end
      release_clk();
    end
    for (int i = 0; i < 4; i++) begin
      compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== seq[i]) begin mismatched++; $display("FAIL overrun_pop_%0d: got v=%b d=%h want v=1 d=%h", i, rxIf.valid, rxIf.data, seq[i]); end
      rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
    end
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL overrun_empty: got %b want 0", rxIf.valid); end
  endtask

  task automatic test_timeout();
    int n;
    send_bits({1'b1, 1'b0, 8'h33, 1'b0}, 5);  // start + 4 data bits
    @(posedge clk); #1;
    ps2Clk = 1'b1;
    n = 0;
    while (n < TIMEOUT + 1000 && rxIf.frameError !== 1'b1) begin
      @(posedge clk); #1;
      n++;
    end
    compared++; if (n < TIMEOUT || n > TIMEOUT + 2) begin mismatched++; $display("FAIL timeout_cycles: got %0d want %0d..%0d", n, TIMEOUT, TIMEOUT + 2); end
    compared++; if (rxIf.busy !== 1'b0) begin mismatched++; $display("FAIL timeout_busy: got %b want 0", rxIf.busy); end
    repeat (H) @(posedge clk);
    #1;
    send_frame(8'h5A, goodParity(8'h5A), 1'b1);
    @(posedge clk); #1;
    compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== 8'h5A || rxIf.frameError !== 1'b0) begin mismatched++; $display("FAIL timeout_recover: got v=%b d=%h e=%b want v=1 d=5a e=0", rxIf.valid, rxIf.data, rxIf.frameError); end
    release_clk();
    rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
  endtask

  task automatic test_stop_error();
    send_frame(8'h45, goodParity(8'h45), 1'b0);
    @(posedge clk); #1;
    compared++; if (rxIf.frameError !== 1'b1) begin mismatched++; $display("FAIL stop_err: got %b want 1", rxIf.frameError); end
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL stop_valid: got %b want 0", rxIf.valid); end
    release_clk();
  endtask

  task automatic test_spurious_edge();
    ps2Data = 1'b1;
    repeat (H) @(posedge clk);
    #1 ps2Clk = 1'b0;
    @(posedge clk); #1;
    compared++; if (rxIf.frameError !== 1'b1 || rxIf.busy !== 1'b0) begin mismatched++; $display("FAIL bad_start: got e=%b b=%b want e=1 b=0", rxIf.frameError, rxIf.busy); end
    release_clk();
    rxIf.ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rxIf.ready = 1'b0;
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL pop_empty: got %b want 0", rxIf.valid); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    q.delete();
    for (int i = 0; i < DEPTH; i++) begin
      b = 8'($urandom);
      send_frame(b, goodParity(b), 1'b1);
      q.push_back(b);
      @(posedge clk); #1;
      release_clk();
    end
    b = 8'($urandom);
    send_frame(b, goodParity(b), 1'b1);
    rxIf.ready = 1'b1;  // pop in the same cycle as the push into a full FIFO
    @(posedge clk); #1;
    rxIf.ready = 1'b0;
    void'(q.pop_front());
    q.push_back(b);
    compared++; if (rxIf.overrun !== 1'b0 || rxIf.frameError !== 1'b0) begin mismatched++; $display("FAIL b2b_pulses: got ov=%b e=%b want 0 0", rxIf.overrun, rxIf.frameError); end
    release_clk();
    while (q.size() > 0) begin
      compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== q[0]) begin mismatched++; $display("FAIL b2b_pop: got v=%b d=%h want v=1 d=%h", rxIf.valid, rxIf.data, q[0]); end
      rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
      void'(q.pop_front());
    end
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL b2b_empty: got %b want 0", rxIf.valid); end
  endtask

  task automatic test_reset_midframe();
    for (int i = 0; i < 2; i++) begin
      send_frame(8'h11 + 8'(i), goodParity(8'h11 + 8'(i)), 1'b1);
      @(posedge clk); #1;
      release_clk();
    end
    compared++; if (rxIf.valid !== 1'b1) begin mismatched++; $display("FAIL rst_mid_prefill: got %b want 1", rxIf.valid); end
    send_bits({1'b1, 1'b0, 8'hA5, 1'b0}, 4);
    @(posedge clk); #1;
    ps2Clk = 1'b1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    compared++; if (rxIf.valid !== 1'b0 || rxIf.busy !== 1'b0) begin mismatched++; $display("FAIL rst_mid: got v=%b b=%b want 0 0", rxIf.valid, rxIf.busy); end
    repeat (H) @(posedge clk);
    #1;
    send_frame(8'h29, goodParity(8'h29), 1'b1);
    @(posedge clk); #1;
    compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== 8'h29) begin mismatched++; $display("FAIL rst_mid_next: got v=%b d=%h want v=1 d=29", rxIf.valid, rxIf.data); end
    release_clk();
    rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
    q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    logic par, stopb, expErr, expOvr;
    int k;
    for (int n = 0; n < 30; n++) begin
      b     = 8'($urandom);
      par   = goodParity(b) ^ ($urandom_range(0, 3) == 0);
      stopb = ($urandom_range(0, 7) != 0);
      send_frame(b, par, stopb);
      expErr = 1'b0;
      expOvr = 1'b0;
      if (frameGood(b, par, stopb)) begin
        if (q.size() < DEPTH) q.push_back(b);
        else expOvr = 1'b1;
      end else begin
        expErr = 1'b1;
      end
      @(posedge clk); #1;
      compared++; if (rxIf.frameError !== expErr || rxIf.overrun !== expOvr) begin mismatched++; $display("FAIL rnd_pulses_%0d: got e=%b ov=%b want e=%b ov=%b", n, rxIf.frameError, rxIf.overrun, expErr, expOvr); end
      compared++; if (rxIf.valid !== (q.size() > 0)) begin mismatched++; $display("FAIL rnd_valid_%0d: got %b want %b", n, rxIf.valid, (q.size() > 0)); end
      if (q.size() > 0) begin
        compared++; if (rxIf.data !== q[0]) begin mismatched++; $display("FAIL rnd_head_%0d: got %h want %h", n, rxIf.data, q[0]); end
      end
      @(posedge clk); #1;
      compared++; if (rxIf.frameError !== 1'b0 || rxIf.overrun !== 1'b0) begin mismatched++; $display("FAIL rnd_width_%0d: got e=%b ov=%b want 0 0", n, rxIf.frameError, rxIf.overrun); end
      release_clk();
      k = (n % 3 == 2) ? int'($urandom_range(0, q.size())) : 0;
      for (int j = 0; j < k; j++) begin
        compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== q[0]) begin mismatched++; $display("FAIL rnd_pop_%0d: got v=%b d=%h want v=1 d=%h", n, rxIf.valid, rxIf.data, q[0]); end
        rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
        void'(q.pop_front());
      end
    end
    while (q.size() > 0) begin
      compared++; if (rxIf.valid !== 1'b1 || rxIf.data !== q[0]) begin mismatched++; $display("FAIL rnd_drain: got v=%b d=%h want v=1 d=%h", rxIf.valid, rxIf.data, q[0]); end
      rxIf.ready = 1'b1; @(posedge clk); #1; rxIf.ready = 1'b0;
      void'(q.pop_front());
    end
    compared++; if (rxIf.valid !== 1'b0) begin mismatched++; $display("FAIL rnd_empty: got %b want 0", rxIf.valid); end
  endtask

  initial begin
    test_reset();
    test_frame_1c();
    test_parity_error();
    test_overrun();
    test_stop_error();
    test_spurious_edge();
    test_timeout();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
